inv_sub_bytes_eng: RTL

INV_SUB_BYTES_ENG -- requirements
Module: inv_sub_bytes_eng

---
 rtl/inv_sub_bytes_eng.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/inv_sub_bytes_eng.sv
// inv_sub_bytes_eng -- multi-cycle AES InvSubBytes engine.
//
// Accepts one 128-bit AES state, transforms BYTES_PER_CYCLE bytes per BUSY
// cycle and presents the full result with a valid/ready handshake. The
// GF(2^8) inversion is composite-field logic over GF(((2^2)^2)^2); no ROM.
//
// Optional feature: define INV_SUB_BYTES_FWD_EN to add mode_i, which selects
// forward SubBytes (mode_i=1) or InvSubBytes (mode_i=0), sampled at accept.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input state offered
//   in_ready   engine idle and able to accept a state
//   state_i    input state, byte k = state_i[127-8k -: 8]
//   mode_i     (INV_SUB_BYTES_FWD_EN only) 1 = forward, 0 = inverse
//   out_valid  result available
//   out_ready  downstream accepts the result
//   state_o    transformed state, same byte order as state_i
//   busy_o     high while transforming
module inv_sub_bytes_eng #(
    parameter int unsigned BYTES_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_i,
`ifdef INV_SUB_BYTES_FWD_EN
    input  logic         mode_i,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_o,
    output logic         busy_o
);

    localparam int unsigned N  = 16 / BYTES_PER_CYCLE;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned W  = 8 * BYTES_PER_CYCLE;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              state;
    logic [CW-1:0]       cnt;
    // Chunk 0 sits at the MSB end so chunk c holds bytes c*BPC .. c*BPC+BPC-1.
    logic [0:N-1][W-1:0] cap;
    logic [0:N-1][W-1:0] res;
    logic [W-1:0]        chunk_in;
    logic [W-1:0]        chunk_out;
`ifdef INV_SUB_BYTES_FWD_EN
    logic                mode;
`endif

    // GF(2^2), polynomial x^2+x+1
    function automatic logic [1:0] gf2_mul(input logic [1:0] a, input logic [1:0] b);
        return {(a[1] & b[1]) ^ (a[1] & b[0]) ^ (a[0] & b[1]),
                (a[1] & b[1]) ^ (a[0] & b[0])};
    endfunction

    function automatic logic [1:0] gf2_sq(input logic [1:0] a);
        return {a[1], a[1] ^ a[0]};
    endfunction

    // multiply by phi = {10}
    function automatic logic [1:0] gf2_phi(input logic [1:0] a);
        return {a[1] ^ a[0], a[1]};
    endfunction

    // GF(2^4) = GF(2^2)[x]/(x^2+x+phi)
    function automatic logic [3:0] gf4_mul(input logic [3:0] q, input logic [3:0] w);
        logic [1:0] hh, hl, lh, ll;
        hh = gf2_mul(q[3:2], w[3:2]);
        hl = gf2_mul(q[3:2], w[1:0]);
        lh = gf2_mul(q[1:0], w[3:2]);
        ll = gf2_mul(q[1:0], w[1:0]);
        return {hh ^ hl ^ lh, gf2_phi(hh) ^ ll};
    endfunction

    function automatic logic [3:0] gf4_sq(input logic [3:0] q);
        return {q[3], q[3] ^ q[2], q[2] ^ q[1], q[3] ^ q[1] ^ q[0]};
    endfunction

    // multiply by lambda = {1100}
    function automatic logic [3:0] gf4_lambda(input logic [3:0] q);
        return {q[2] ^ q[0], q[3] ^ q[2] ^ q[1] ^ q[0], q[3], q[2]};
    endfunction

    // (h*x + l)^-1 = (h*x + (h+l)) / (h^2*phi + h*l + l^2); in GF(4) a^-1 = a^2
    function automatic logic [3:0] gf4_inv(input logic [3:0] q);
        logic [1:0] d, di;
        d  = gf2_phi(gf2_sq(q[3:2])) ^ gf2_mul(q[3:2], q[1:0]) ^ gf2_sq(q[1:0]);
        di = gf2_sq(d);
        return {gf2_mul(q[3:2], di), gf2_mul(q[3:2] ^ q[1:0], di)};
    endfunction

    // polynomial basis (mod 0x11B) -> composite basis
    function automatic logic [7:0] map_in(input logic [7:0] a);
        return {a[7] ^ a[5],
                a[7] ^ a[6] ^ a[4] ^ a[3] ^ a[2] ^ a[1],
                a[7] ^ a[5] ^ a[3] ^ a[2],
                a[7] ^ a[5] ^ a[3] ^ a[2] ^ a[1],
                a[7] ^ a[6] ^ a[2] ^ a[1],
                a[7] ^ a[4] ^ a[3] ^ a[2] ^ a[1],
                a[6] ^ a[4] ^ a[1],
                a[6] ^ a[1] ^ a[0]};
    endfunction

    // composite basis -> polynomial basis
    function automatic logic [7:0] map_out(input logic [7:0] a);
        return {a[7] ^ a[6] ^ a[5] ^ a[1],
                a[6] ^ a[2],
                a[6] ^ a[5] ^ a[1],
                a[6] ^ a[5] ^ a[4] ^ a[2] ^ a[1],
                a[5] ^ a[4] ^ a[3] ^ a[2] ^ a[1],
                a[7] ^ a[4] ^ a[3] ^ a[2] ^ a[1],
                a[5] ^ a[4],
                a[6] ^ a[5] ^ a[4] ^ a[2] ^ a[0]};
    endfunction

    // GF(2^8) inverse with 0 -> 0; lambda = {1100} in x^2+x+lambda
    function automatic logic [7:0] gf8_inv(input logic [7:0] a);
        logic [7:0] m;
        logic [3:0] d, di;
        m  = map_in(a);
        d  = gf4_lambda(gf4_sq(m[7:4])) ^ gf4_mul(m[7:4], m[3:0]) ^ gf4_sq(m[3:0]);
        di = gf4_inv(d);
        return map_out({gf4_mul(m[7:4], di), gf4_mul(m[7:4] ^ m[3:0], di)});
    endfunction

    // t = rotl(x,1) ^ rotl(x,3) ^ rotl(x,6) ^ 0x05
    function automatic logic [7:0] affine_inv(input logic [7:0] x);
        return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    endfunction

`ifdef INV_SUB_BYTES_FWD_EN
    function automatic logic [7:0] affine_fwd(input logic [7:0] v);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
                 ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    // Both directions pass through one inverter; only the affine steps are muxed.
    function automatic logic [7:0] xform(input logic [7:0] x, input logic fwd);
        logic [7:0] y;
        y = gf8_inv(fwd ? x : affine_inv(x));
        return fwd ? affine_fwd(y) : y;
    endfunction
`else
    function automatic logic [7:0] xform(input logic [7:0] x);
        return gf8_inv(affine_inv(x));
    endfunction
`endif

    assign chunk_in = cap[cnt];

    for (genvar j = 0; j < int'(BYTES_PER_CYCLE); j++) begin : g_lane
`ifdef INV_SUB_BYTES_FWD_EN
        assign chunk_out[W-1-8*j -: 8] = xform(chunk_in[W-1-8*j -: 8], mode);
`else
        assign chunk_out[W-1-8*j -: 8] = xform(chunk_in[W-1-8*j -: 8]);
`endif
    end

    assign state_o = res;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            cap       <= '0;
            res       <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy_o    <= 1'b0;
`ifdef INV_SUB_BYTES_FWD_EN
            mode      <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    // in_ready is registered, so it only rises on the first edge after reset
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        cap      <= state_i;
                        cnt      <= '0;
                        state    <= BUSY;
                        in_ready <= 1'b0;
                        busy_o   <= 1'b1;
`ifdef INV_SUB_BYTES_FWD_EN
                        mode     <= mode_i;
`endif
                    end
                end
                BUSY: begin
                    res[cnt] <= chunk_out;
                    if (cnt == LAST) begin
                        cnt       <= '0;
                        state     <= DONE;
                        busy_o    <= 1'b0;
                        out_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
